// File: rtl/find_one.sv
// Registered LSB-first priority encoder: index of the lowest set bit plus a found flag.
// Optional FIND_ONE_MULTI_FLAG_EN adds a registered "two or more bits set" flag.
module find_one #(
    parameter int IN_WIDTH  = 6,
    parameter int OUT_WIDTH = $clog2(IN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 found,
    output logic                 out_valid
`ifdef FIND_ONE_MULTI_FLAG_EN
    ,
    output logic                 multi
`endif
);

    logic [OUT_WIDTH-1:0] idx_scan;
    logic [OUT_WIDTH-1:0] out_d, out_q;
    logic                 found_d, found_q;
    logic                 valid_q;

    // Scan from the top down so the lowest set index is the last assignment to win.
    always_comb begin
        idx_scan = '1;
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx_scan = OUT_WIDTH'(i);
            end
        end
    end

    // Outputs only load on an accepted vector, so X on in while idle never reaches them.
    always_comb begin
        out_d   = out_q;
        found_d = found_q;
        if (in_valid) begin
            out_d   = idx_scan;
            found_d = |in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '1;
            found_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            found_q <= found_d;
            valid_q <= in_valid;
        end
    end

`ifdef FIND_ONE_MULTI_FLAG_EN
    logic multi_d, multi_q;

    // Clearing the lowest set bit leaves something only if a second bit was set.
    always_comb begin
        multi_d = multi_q;
        if (in_valid) begin
            multi_d = |(in & (in - IN_WIDTH'(1)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            multi_q <= 1'b0;
        end else begin
            multi_q <= multi_d;
        end
    end

    assign multi = multi_q;
`endif

    assign out       = out_q;
    assign found     = found_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_find_one.sv
// Directed bench for find_one: a 6-bit instance for the main checks and an 8-bit
// instance for the power-of-two sentinel aliasing case.
module tb_find_one;

    logic       clk;
    logic       rst_n;
    logic       in_valid6;
    logic [5:0] in6;
    logic [2:0] out6;
    logic       found6;
    logic       out_valid6;
    logic       in_valid8;
    logic [7:0] in8;
    logic [2:0] out8;
    logic       found8;
    logic       out_valid8;
`ifdef FIND_ONE_MULTI_FLAG_EN
    logic       multi6;
    logic       multi8;
`endif

    int tests_run;
    int tests_failed;

    find_one #(.IN_WIDTH(6), .OUT_WIDTH(3)) u_dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid6),
        .in        (in6),
        .out       (out6),
        .found     (found6),
        .out_valid (out_valid6)
`ifdef FIND_ONE_MULTI_FLAG_EN
        ,
        .multi     (multi6)
`endif
    );

    find_one #(.IN_WIDTH(8), .OUT_WIDTH(3)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in        (in8),
        .out       (out8),
        .found     (found8),
        .out_valid (out_valid8)
`ifdef FIND_ONE_MULTI_FLAG_EN
        ,
        .multi     (multi8)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running required done");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Apply one cycle of inputs to both instances; return #1 after the capturing edge.
    task automatic drive(input logic v6, input logic [5:0] d6, input logic v8, input logic [7:0] d8);
        @(negedge clk);
        in_valid6 = v6;
        in6       = d6;
        in_valid8 = v8;
        in8       = d8;
        @(posedge clk);
        #1;
    endtask

    task automatic check6(input string tag, input logic [2:0] e_out, input logic e_found, input logic e_valid);
        check_eq({tag, ".out"},       32'(out6),       32'(e_out));
        check_eq({tag, ".found"},     32'(found6),     32'(e_found));
        check_eq({tag, ".out_valid"}, 32'(out_valid6), 32'(e_valid));
    endtask

    task automatic check8(input string tag, input logic [2:0] e_out, input logic e_found, input logic e_valid);
        check_eq({tag, ".out"},       32'(out8),       32'(e_out));
        check_eq({tag, ".found"},     32'(found8),     32'(e_found));
        check_eq({tag, ".out_valid"}, 32'(out_valid8), 32'(e_valid));
    endtask

    task automatic check_multi6(input string tag, input logic e_multi);
`ifdef FIND_ONE_MULTI_FLAG_EN
        check_eq({tag, ".multi"}, 32'(multi6), 32'(e_multi));
`else
        if (tag.len() < 0) $display("%0d", e_multi);
`endif
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        in_valid6 = 1'b0;
        in6       = 6'd0;
        in_valid8 = 1'b0;
        in8       = 8'd0;
        rst_n     = 1'b1;

        // Asynchronous reset before any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check6("reset_async", 3'd7, 1'b0, 1'b0);
        check8("reset_async8", 3'd7, 1'b0, 1'b0);
        check_multi6("reset_async", 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 6'b111111, 1'b0, 8'hff);
        check6("reset_hold", 3'd7, 1'b0, 1'b0);

        // One-hot sweep
        drive(1'b1, 6'b001000, 1'b0, 8'h00);
        check6("onehot3", 3'd3, 1'b1, 1'b1);
        check_multi6("onehot3", 1'b0);
        drive(1'b1, 6'b100000, 1'b0, 8'h00);
        check6("onehot5", 3'd5, 1'b1, 1'b1);
        drive(1'b1, 6'b000010, 1'b0, 8'h00);
        check6("onehot1", 3'd1, 1'b1, 1'b1);
        drive(1'b1, 6'b000001, 1'b0, 8'h00);
        check6("onehot0", 3'd0, 1'b1, 1'b1);

        // Zero vector
        drive(1'b1, 6'b000000, 1'b0, 8'h00);
        check6("zero", 3'd7, 1'b0, 1'b1);
        check_multi6("zero", 1'b0);

        // Multiple bits set
        drive(1'b1, 6'b101100, 1'b0, 8'h00);
        check6("multi101100", 3'd2, 1'b1, 1'b1);
        check_multi6("multi101100", 1'b1);
        drive(1'b1, 6'b010000, 1'b0, 8'h00);
        check6("single010000", 3'd4, 1'b1, 1'b1);
        check_multi6("single010000", 1'b0);
        drive(1'b1, 6'b101000, 1'b0, 8'h00);
        check6("multi101000", 3'd3, 1'b1, 1'b1);
        check_multi6("multi101000", 1'b1);
        drive(1'b1, 6'b111111, 1'b0, 8'h00);
        check6("all_ones", 3'd0, 1'b1, 1'b1);

        // Hold a found value through idle cycles
        drive(1'b1, 6'b010000, 1'b0, 8'h00);
        check6("pre_hold", 3'd4, 1'b1, 1'b1);
        drive(1'b0, 6'b000001, 1'b0, 8'h00);
        check6("hold_found_a", 3'd4, 1'b1, 1'b0);
        drive(1'b0, 6'b110011, 1'b0, 8'h00);
        check6("hold_found_b", 3'd4, 1'b1, 1'b0);
        check_multi6("hold_found_b", 1'b0);

        // Back-to-back then idle with changing input
        drive(1'b1, 6'b000100, 1'b0, 8'h00);
        check6("b2b_0", 3'd2, 1'b1, 1'b1);
        drive(1'b1, 6'b100001, 1'b0, 8'h00);
        check6("b2b_1", 3'd0, 1'b1, 1'b1);
        check_multi6("b2b_1", 1'b1);
        drive(1'b1, 6'b000000, 1'b0, 8'h00);
        check6("b2b_2", 3'd7, 1'b0, 1'b1);
        drive(1'b0, 6'b101010, 1'b0, 8'h00);
        check6("idle_a", 3'd7, 1'b0, 1'b0);
        drive(1'b0, 6'b000011, 1'b0, 8'h00);
        check6("idle_b", 3'd7, 1'b0, 1'b0);
        check_multi6("idle_b", 1'b0);

        // Reset mid-stream, away from any clock edge
        drive(1'b1, 6'b000110, 1'b1, 8'h40);
        check6("pre_rst", 3'd1, 1'b1, 1'b1);
        check8("pre_rst8", 3'd6, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check6("mid_rst", 3'd7, 1'b0, 1'b0);
        check8("mid_rst8", 3'd7, 1'b0, 1'b0);
        check_multi6("mid_rst", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 6'b001000, 1'b0, 8'h00);
        check6("post_rst", 3'd3, 1'b1, 1'b1);

        // Power-of-two width: sentinel aliases the top index
        drive(1'b0, 6'b000000, 1'b1, 8'h80);
        check8("pow2_top", 3'd7, 1'b1, 1'b1);
        drive(1'b0, 6'b000000, 1'b1, 8'h00);
        check8("pow2_zero", 3'd7, 1'b0, 1'b1);
        drive(1'b0, 6'b000000, 1'b1, 8'h12);
        check8("pow2_12", 3'd1, 1'b1, 1'b1);
        drive(1'b0, 6'b000000, 1'b0, 8'h01);
        check8("pow2_hold", 3'd1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
